// File: rtl/instr_decode_stage.sv
// Instruction decode stage: registered decode into a 1- or 2-entry output buffer with valid/ready handshakes.
// Optional illegal C-instruction flag is compiled in with INSTR_DECODE_ILLEGAL_CHECK_EN.
module instr_decode_stage #(
    parameter int BUS_WIDTH = 16,
    parameter int DEPTH     = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [BUS_WIDTH-1:0] i_X,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic                 o_valid,
    input  logic                 i_ready,
    input  logic                 i_flush,
    output logic                 o_ci,
    output logic                 o_sm,
    output logic                 o_zx,
    output logic                 o_nx,
    output logic                 o_zy,
    output logic                 o_ny,
    output logic                 o_f,
    output logic                 o_no,
    output logic                 o_a,
    output logic                 o_d,
    output logic                 o_p,
    output logic                 o_gt,
    output logic                 o_eq,
    output logic                 o_lt,
    output logic [BUS_WIDTH-1:0] o_W,
    output logic                 o_illegal
);

    localparam int FLAG_W   = 14;
    localparam int BUNDLE_W = FLAG_W + BUS_WIDTH;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [BUNDLE_W-1:0]   head_q, head_d;
    logic [BUNDLE_W-1:0]   tail_q, tail_d;
    logic [BUNDLE_W-1:0]   inBundle;
    logic                  readyState;
    logic                  pushEn;
    logic                  popEn;

    // Bundle layout, MSB first: ci sm zx nx zy ny f no a d p gt eq lt, then W.
    function automatic logic [BUNDLE_W-1:0] decode(input logic [BUS_WIDTH-1:0] x);
        logic c;
        c = x[BUS_WIDTH-1];
        decode = {c, x[12] & c, x[11] & c, x[10] & c, x[9] & c, x[8] & c,
                  x[7] & c, x[6] & c, ~(c & ~x[5]), x[4] & c, x[3] & c,
                  x[2] & c, x[1] & c, x[0] & c,
                  (c ? {BUS_WIDTH{1'b0}} : x)};
    endfunction

    assign inBundle = decode(i_X);

    always_comb begin
        readyState = 1'b0;
        case (state_q)
            EMPTY:   readyState = 1'b1;
            ONE:     readyState = (DEPTH == 2) ? 1'b1 : i_ready;
            default: readyState = 1'b0;
        endcase
    end

    assign o_ready = readyState & ~i_reset;
    assign o_valid = (state_q != EMPTY);
    assign pushEn  = i_valid & o_ready;
    assign popEn   = o_valid & i_ready;

`ifdef INSTR_DECODE_ILLEGAL_CHECK_EN
    logic headIllegal_q, headIllegal_d;
    logic tailIllegal_q, tailIllegal_d;
    logic inIllegal;

    // A C-instruction must have every bit between the opcode bit and the ALU field set.
    assign inIllegal = i_X[BUS_WIDTH-1] & ~(&i_X[BUS_WIDTH-2:13]);
`endif

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
`ifdef INSTR_DECODE_ILLEGAL_CHECK_EN
        headIllegal_d = headIllegal_q;
        tailIllegal_d = tailIllegal_q;
`endif
        if (i_flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (pushEn) begin
                        head_d  = inBundle;
`ifdef INSTR_DECODE_ILLEGAL_CHECK_EN
                        headIllegal_d = inIllegal;
`endif
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (pushEn && popEn) begin
                        head_d = inBundle;
`ifdef INSTR_DECODE_ILLEGAL_CHECK_EN
                        headIllegal_d = inIllegal;
`endif
                    end else if (pushEn && (DEPTH == 2)) begin
                        tail_d  = inBundle;
`ifdef INSTR_DECODE_ILLEGAL_CHECK_EN
                        tailIllegal_d = inIllegal;
`endif
                        state_d = FULL;
                    end else if (popEn) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // o_ready is low here, so only a pop can occur; the tail moves up.
                    if (popEn) begin
                        head_d  = tail_q;
`ifdef INSTR_DECODE_ILLEGAL_CHECK_EN
                        headIllegal_d = tailIllegal_q;
`endif
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

`ifdef INSTR_DECODE_ILLEGAL_CHECK_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            headIllegal_q <= 1'b0;
            tailIllegal_q <= 1'b0;
        end else begin
            headIllegal_q <= headIllegal_d;
            tailIllegal_q <= tailIllegal_d;
        end
    end

    assign o_illegal = o_valid & headIllegal_q;
`else
    assign o_illegal = 1'b0;
`endif

    // Stale head contents stay hidden once the buffer drains.
    assign {o_ci, o_sm, o_zx, o_nx, o_zy, o_ny, o_f, o_no,
            o_a, o_d, o_p, o_gt, o_eq, o_lt, o_W} = o_valid ? head_q : {BUNDLE_W{1'b0}};

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench for instr_decode_stage: a monitor compares every cycle against a queue-based model.
module tb_instr_decode_stage;

    localparam int BW    = 16;
    localparam int DEPTH = 2;

    logic          i_clk;
    logic          i_reset;
    logic [BW-1:0] i_X;
    logic          i_valid;
    logic          o_ready;
    logic          o_valid;
    logic          i_ready;
    logic          i_flush;
    logic          o_ci, o_sm, o_zx, o_nx, o_zy, o_ny, o_f, o_no;
    logic          o_a, o_d, o_p, o_gt, o_eq, o_lt;
    logic [BW-1:0] o_W;
    logic          o_illegal;

    int testsRun = 0;
    int testsFailed = 0;
    logic [63:0] model[$];

    instr_decode_stage #(.BUS_WIDTH(BW), .DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_X(i_X), .i_valid(i_valid),
        .o_ready(o_ready), .o_valid(o_valid), .i_ready(i_ready), .i_flush(i_flush),
        .o_ci(o_ci), .o_sm(o_sm), .o_zx(o_zx), .o_nx(o_nx), .o_zy(o_zy), .o_ny(o_ny),
        .o_f(o_f), .o_no(o_no), .o_a(o_a), .o_d(o_d), .o_p(o_p), .o_gt(o_gt),
        .o_eq(o_eq), .o_lt(o_lt), .o_W(o_W), .o_illegal(o_illegal)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [63:0] packFields(
        input logic ci, input logic sm, input logic zx, input logic nx, input logic zy,
        input logic ny, input logic f, input logic no, input logic a, input logic d,
        input logic p, input logic gt, input logic eq, input logic lt, input logic ill,
        input logic [BW-1:0] w);
        return 64'({ci, sm, zx, nx, zy, ny, f, no, a, d, p, gt, eq, lt, ill, w});
    endfunction

    // Reference decode written from the instruction format: A-instructions carry a literal,
    // C-instructions carry control bits and a = X[5].
    function automatic logic [63:0] refDecode(input logic [BW-1:0] x);
        logic ill;
        ill = 1'b0;
        if (x[BW-1] == 1'b0)
            return packFields(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, x);
`ifdef INSTR_DECODE_ILLEGAL_CHECK_EN
        for (int b = 13; b <= BW - 2; b++)
            if (x[b] == 1'b0) ill = 1'b1;
`endif
        return packFields(1'b1, x[12], x[11], x[10], x[9], x[8], x[7], x[6],
                          x[5], x[4], x[3], x[2], x[1], x[0], ill, '0);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs; returns just after the next rising edge.
    task automatic applyStimulus(input logic valid, input logic [BW-1:0] x, input logic ready, input logic flush);
        i_valid = valid;
        i_X     = x;
        i_ready = ready;
        i_flush = flush;
        @(posedge i_clk);
        #1;
    endtask

    // Monitor: compares outputs to the model head each cycle, then applies the cycle's transfers.
    initial begin : monitor
        int expSize;
        logic expReady;
        logic [63:0] actual;
        forever begin
            @(negedge i_clk);
            if (!i_reset) begin
                expSize  = model.size();
                expReady = (expSize < DEPTH);
                actual   = packFields(o_ci, o_sm, o_zx, o_nx, o_zy, o_ny, o_f, o_no,
                                      o_a, o_d, o_p, o_gt, o_eq, o_lt, o_illegal, o_W);
                checkOutput("o_valid", 64'(o_valid), 64'(expSize != 0));
                checkOutput("o_ready", 64'(o_ready), 64'(expReady));
                checkOutput("bundle", actual, (expSize != 0) ? model[0] : 64'd0);
                if (i_flush) begin
                    model.delete();
                end else begin
                    if (expSize != 0 && i_ready) void'(model.pop_front());
                    if (i_valid && expReady) model.push_back(refDecode(i_X));
                end
            end
        end
    end

    initial begin : stimulus
        logic [BW-1:0] words[3];
        logic [BW-1:0] rx;
        logic acc;
        int sent;

        i_reset = 1'b1;
        i_valid = 1'b0;
        i_X     = '0;
        i_ready = 1'b0;
        i_flush = 1'b0;
        #3;
        checkOutput("reset_valid", 64'(o_valid), 64'd0);
        checkOutput("reset_ready", 64'(o_ready), 64'd0);
        checkOutput("reset_W", 64'(o_W), 64'd0);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        #1;
        checkOutput("post_reset_ready", 64'(o_ready), 64'd1);

        // A-instruction
        applyStimulus(1'b1, 16'h1234, 1'b1, 1'b0);
        checkOutput("a_valid", 64'(o_valid), 64'd1);
        checkOutput("a_W", 64'(o_W), 64'h1234);
        checkOutput("a_flags", 64'({o_ci, o_a, o_sm, o_zx, o_nx, o_d, o_illegal}), 64'b0100000);

        // C-instruction
        applyStimulus(1'b1, 16'hEC10, 1'b1, 1'b0);
        checkOutput("c_flags", 64'({o_ci, o_sm, o_zx, o_nx, o_zy, o_ny, o_f, o_no,
                                    o_a, o_d, o_p, o_gt, o_eq, o_lt}), 64'b10110000010000);
        checkOutput("c_W", 64'(o_W), 64'd0);
        checkOutput("c_illegal", 64'(o_illegal), 64'd0);

        // Illegal C-instruction (bit 14 clear)
        applyStimulus(1'b1, 16'hA000, 1'b1, 1'b0);
`ifdef INSTR_DECODE_ILLEGAL_CHECK_EN
        checkOutput("illegal_flag", 64'(o_illegal), 64'd1);
`else
        checkOutput("illegal_flag", 64'(o_illegal), 64'd0);
`endif
        checkOutput("illegal_ci", 64'(o_ci), 64'd1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Backpressure: three words against a stalled consumer
        words[0] = 16'h0111;
        words[1] = 16'h0222;
        words[2] = 16'h0333;
        sent = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            acc = o_ready;
            applyStimulus(1'b1, words[(sent < 3) ? sent : 2], 1'b0, 1'b0);
            if (acc && sent < 3) sent++;
        end
        checkOutput("bp_accepted", 64'(sent), 64'd2);
        checkOutput("bp_ready_low", 64'(o_ready), 64'd0);
        checkOutput("bp_head_stable", 64'(o_W), 64'h0111);
        for (int cyc = 0; cyc < 10; cyc++) begin
            acc = o_ready;
            applyStimulus(sent < 3, words[(sent < 3) ? sent : 2], 1'b1, 1'b0);
            if (acc && sent < 3) sent++;
        end
        checkOutput("bp_all_sent", 64'(sent), 64'd3);
        checkOutput("bp_drained", 64'(o_valid), 64'd0);

        // Flush from FULL with a concurrent input
        applyStimulus(1'b1, 16'h0AAA, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0BBB, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0CCC, 1'b0, 1'b1);
        checkOutput("flush_valid", 64'(o_valid), 64'd0);
        checkOutput("flush_ready", 64'(o_ready), 64'd1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("flush_no_leak", 64'(o_valid), 64'd0);

        // Asynchronous reset while one entry is held
        applyStimulus(1'b1, 16'h0777, 1'b0, 1'b0);
        i_valid = 1'b0;
        #1;
        i_reset = 1'b1;
        model.delete();
        #1;
        checkOutput("areset_valid", 64'(o_valid), 64'd0);
        checkOutput("areset_ready", 64'(o_ready), 64'd0);
        checkOutput("areset_W", 64'(o_W), 64'd0);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        #1;
        checkOutput("areset_release_ready", 64'(o_ready), 64'd1);
        checkOutput("areset_release_valid", 64'(o_valid), 64'd0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            rx = BW'($urandom);
            if ($urandom_range(0, 3) != 0) rx[BW-2:13] = '1;
            applyStimulus(1'($urandom_range(0, 1)), rx, ($urandom_range(0, 2) != 0),
                          ($urandom_range(0, 24) == 0));
        end
        for (int n = 0; n < 5; n++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("final_empty", 64'(o_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
